// File: rtl/tc_register_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// tc_register_arbiter_pkg
// Shared types and helpers for the TC register-bank arbiter.
//   state_t     : arbiter FSM states (IDLE, ACCESS)
//   OP_READ/OP_WRITE : encoding of the per-requester req_write bit
//   addr_match  : one-hot address decode helper. It answers "does this
//                 address select register idx?" and is used bit-by-bit to
//                 build the save/load strobe vectors.
// ---------------------------------------------------------------------------
package tc_register_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // An address outside the bank never selects any register, so an
  // out-of-range access produces no strobe at all.
  function automatic logic addr_match(input logic [31:0] addr,
                                      input int unsigned idx,
                                      input int unsigned nreg);
    return (addr < nreg) && (addr == idx);
  endfunction

endpackage

// File: rtl/tc_rr_picker.sv
// ---------------------------------------------------------------------------
// tc_rr_picker
// Combinational round-robin picker, shared by the shared-resource controllers.
// The search starts at ptr+1 and wraps, so the requester granted last
// (ptr) gets the lowest priority.
// Ports:
//   req   in  N        request vector
//   ptr   in  IW       index of the last grant
//   grant out IW       index of the winning requester (0 when none)
//   any   out 1        at least one request is present
// ---------------------------------------------------------------------------
module tc_rr_picker #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any
);

  logic [IW-1:0] idx;

  // Walk the offsets from farthest to nearest; the last hit written wins,
  // so the requester closest after ptr ends up as the grant.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |req;
    for (int off = N; off >= 1; off--) begin
      idx = IW'((int'(ptr) + off) % N);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/tc_register_arbiter.sv
// ---------------------------------------------------------------------------
// tc_register_arbiter
// Shares a bank of NREG TC-style registers between NREQ requesters with a
// round-robin req/ready handshake. One access every two cycles: IDLE picks
// and captures a winner, ACCESS drives the bank strobes for one cycle.
// Optional build macro: TC_REGISTER_ARBITER_LOCK_EN (adds req_lock, lets a
// requester keep the bank across consecutive accesses).
// Ports:
//   clk        in  1            clock, rising edge
//   rst        in  1            asynchronous reset, active low
//   req_valid  in  NREQ         per-requester request
//   req_write  in  NREQ         1 = write (save), 0 = read (load)
//   req_addr   in  NREQ*AW      packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in  NREQ*WIDTH   packed write data, requester i at [i*WIDTH +: WIDTH]
//   req_lock   in  NREQ         lock request (LOCK_EN builds only)
//   req_ready  out NREQ         one-hot, one-cycle acknowledge
//   rsp_valid  out NREQ         one-hot, one-cycle read-data-valid
//   rsp_rdata  out WIDTH        read data, held until the next read completes
//   reg_save   out NREG         one-hot save strobe to the bank
//   reg_load   out NREG         one-hot load strobe to the bank
//   reg_in     out WIDTH        write data to the bank
//   reg_out    in  WIDTH        OR-combined bank output
//   grant_id   out log2(NREQ)   index of the current or last grant
// ---------------------------------------------------------------------------
module tc_register_arbiter
  import tc_register_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NREG  = 8,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(NREG),
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_write,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_wdata,
`ifdef TC_REGISTER_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic [NREG-1:0]       reg_save,
  output logic [NREG-1:0]       reg_load,
  output logic [WIDTH-1:0]      reg_in,
  input  logic [WIDTH-1:0]      reg_out,
  output logic [IW-1:0]         grant_id
);

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     pick_id;
  logic              pick_any;
  logic [IW-1:0]     win_id;
  logic              win_valid;
  logic              cap_write;
  logic [AW-1:0]     cap_addr;
  logic [WIDTH-1:0]  cap_wdata;
  logic [IW-1:0]     grant_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [WIDTH-1:0]  rsp_rdata_q;
  logic              addr_in_range;

  tc_rr_picker #(.N(NREQ)) u_picker (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_id),
    .any   (pick_any)
  );

`ifdef TC_REGISTER_ARBITER_LOCK_EN
  logic          lock_active;
  logic [IW-1:0] lock_id;
  logic          lock_hit;
  logic          locked_grant;

  assign lock_hit = lock_active && req_valid[lock_id];

  // A lock owner that is still requesting overrides the round-robin choice.
  always_comb begin
    win_valid = pick_any;
    win_id    = pick_id;
    if (lock_hit) begin
      win_valid = 1'b1;
      win_id    = lock_id;
    end
  end

  // Lock ownership: taken when the granted requester holds req_lock during
  // ACCESS, dropped when the owner finishes an unlocked access or stops
  // requesting. locked_grant remembers that the current access bypassed
  // round-robin so the pointer stays where it was.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_active  <= 1'b0;
      lock_id      <= '0;
      locked_grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lock_active && !req_valid[lock_id]) begin
            lock_active <= 1'b0;
          end
          if (win_valid) begin
            locked_grant <= lock_hit;
          end
        end
        ACCESS: begin
          if (req_lock[grant_q]) begin
            lock_active <= 1'b1;
            lock_id     <= grant_q;
          end else if (lock_active && (lock_id == grant_q)) begin
            lock_active <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
`else
  assign win_valid = pick_any;
  assign win_id    = pick_id;
`endif

  assign addr_in_range = 32'(cap_addr) < 32'(NREG);

  // Next-state and bank-side outputs. Everything bank-facing is decoded from
  // the registered state, so an asynchronous reset drops the strobes at once.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    reg_save  = '0;
    reg_load  = '0;
    reg_in    = '0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt          = IDLE;
        req_ready[grant_q] = 1'b1;
        for (int i = 0; i < NREG; i++) begin
          if (addr_match(32'(cap_addr), i, NREG)) begin
            if (cap_write == OP_WRITE) begin
              reg_save[i] = 1'b1;
            end else begin
              reg_load[i] = 1'b1;
            end
          end
        end
        if (cap_write == OP_WRITE) begin
          reg_in = cap_wdata;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Main sequencing: capture the winner's request in IDLE so a requester may
  // withdraw right after the grant, then in ACCESS advance the pointer and
  // latch read data for the response cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= IW'(NREQ - 1);
      cap_write   <= OP_READ;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            cap_write <= req_write[win_id];
            cap_addr  <= req_addr[int'(win_id)*AW +: AW];
            cap_wdata <= req_wdata[int'(win_id)*WIDTH +: WIDTH];
            grant_q   <= win_id;
          end
        end
        ACCESS: begin
`ifdef TC_REGISTER_ARBITER_LOCK_EN
          if (!locked_grant) begin
            ptr <= grant_q;
          end
`else
          ptr <= grant_q;
`endif
          if (cap_write == OP_READ) begin
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_rdata_q          <= addr_in_range ? reg_out : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign grant_id  = grant_q;

endmodule
